// File: rtl/vend_pkg.sv
// vend_pkg: shared vending types, denominations and default amount width.
package vend_pkg;
   localparam int DEF_AMT_W = 3;
   localparam int COIN1 = 1;
   localparam int COIN2 = 2;
   typedef enum logic [2:0] {IDLE, SELECT, EJECT, WAIT_ACK, DONE} disp_state_t;
endpackage

// File: rtl/dispense_timer.sv
// dispense_timer: loadable down-counter with terminal-count flag.
module dispense_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] val,
   input  logic         en,
   output logic         tc
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= '0;
      else if (load) cnt <= val;
      else if (en && cnt != '0) cnt <= cnt - W'(1);
   assign tc = cnt == '0;
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a requested amount from 2- and 1-unit hoppers,
// one acknowledged coin at a time, with jam fallback and inventory tracking.
module change_dispenser
   import vend_pkg::*;
#(
   parameter int AMT_W        = DEF_AMT_W,
   parameter int CNT_W        = 6,
   parameter int PULSE_CYCLES = 4,
   parameter int ACK_TIMEOUT  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic [AMT_W-1:0] amount,
   input  logic             inv_load,
   input  logic [CNT_W-1:0] inv1_in,
   input  logic [CNT_W-1:0] inv2_in,
   input  logic             hop_ack,
   output logic             ej1,
   output logic             ej2,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [AMT_W-1:0] paid,
   output logic [AMT_W-1:0] short,
   output logic [CNT_W-1:0] inv1,
   output logic [CNT_W-1:0] inv2
);
   localparam int TMAX = PULSE_CYCLES > ACK_TIMEOUT ? PULSE_CYCLES : ACK_TIMEOUT;
   localparam int TW = $clog2(TMAX + 1);
   disp_state_t state, state_n;
   logic [AMT_W-1:0] rem, rem_n, paid_n, short_n, cv;
   logic [CNT_W-1:0] inv1_n, inv2_n;
   logic c2, c2_n, ack_l, ack_n, err_n, t_load, tc;
   logic [TW-1:0] t_val;

   dispense_timer #(.W(TW)) u_timer (
      .clk (clk),
      .rst (rst),
      .load(t_load),
      .val (t_val),
      .en  (state == EJECT || state == WAIT_ACK),
      .tc  (tc)
   );

   assign cv = c2 ? AMT_W'(COIN2) : AMT_W'(COIN1);

   always_comb begin
      state_n = state;
      rem_n   = rem;
      paid_n  = paid;
      short_n = short;
      err_n   = err;
      inv1_n  = inv1;
      inv2_n  = inv2;
      c2_n    = c2;
      ack_n   = ack_l;
      t_load  = 1'b0;
      t_val   = '0;
      case (state)
         IDLE: begin
            if (inv_load) begin
               inv1_n = inv1_in;
               inv2_n = inv2_in;
            end
            if (req) begin
               rem_n   = amount;
               paid_n  = '0;
               short_n = '0;
               err_n   = 1'b0;
               state_n = SELECT;
            end
         end
         SELECT: begin
            ack_n = 1'b0;
            if (rem != '0 && (rem >= AMT_W'(COIN2) && inv2 != '0 || inv1 != '0)) begin
               c2_n    = rem >= AMT_W'(COIN2) && inv2 != '0;
               t_load  = 1'b1;
               t_val   = TW'(PULSE_CYCLES - 1);
               state_n = EJECT;
            end else begin
               short_n = rem;
               err_n   = err || rem != '0;
               state_n = DONE;
            end
         end
         EJECT: begin
            ack_n = ack_l || hop_ack;
            if (tc) begin
               t_load  = 1'b1;
               t_val   = TW'(ACK_TIMEOUT - 1);
               state_n = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            ack_n = 1'b0;
            if (hop_ack || ack_l) begin
               rem_n   = rem - cv;
               paid_n  = paid + cv;
               inv1_n  = c2 ? inv1 : inv1 - CNT_W'(1);
               inv2_n  = c2 ? inv2 - CNT_W'(1) : inv2;
               state_n = SELECT;
            end else if (tc) begin
               // jam: retire the denomination so SELECT falls back
               inv1_n  = c2 ? inv1 : '0;
               inv2_n  = c2 ? '0 : inv2;
               err_n   = 1'b1;
               state_n = SELECT;
            end
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         rem   <= '0;
         paid  <= '0;
         short <= '0;
         err   <= 1'b0;
         inv1  <= '0;
         inv2  <= '0;
         c2    <= 1'b0;
         ack_l <= 1'b0;
         ej1   <= 1'b0;
         ej2   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         rem   <= rem_n;
         paid  <= paid_n;
         short <= short_n;
         err   <= err_n;
         inv1  <= inv1_n;
         inv2  <= inv2_n;
         c2    <= c2_n;
         ack_l <= ack_n;
         ej1   <= state_n == EJECT && !c2_n;
         ej2   <= state_n == EJECT && c2_n;
         busy  <= state_n == SELECT || state_n == EJECT || state_n == WAIT_ACK;
         done  <= state_n == DONE;
      end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed payout scenarios against hand-computed results.
module tb_change_dispenser;
   logic       clk = 1'b0, rst = 1'b0, req = 1'b0, inv_load = 1'b0, hop_ack = 1'b0;
   logic [2:0] amount = '0;
   logic [5:0] inv1_in = '0, inv2_in = '0;
   logic       ej1, ej2, busy, done, err;
   logic [2:0] paid, short;
   logic [5:0] inv1, inv2;
   int n_chk = 0, n_pass = 0;
   int n1, n2, w1, w2, cyc, both;

   change_dispenser dut (
      .clk(clk), .rst(rst), .req(req), .amount(amount), .inv_load(inv_load),
      .inv1_in(inv1_in), .inv2_in(inv2_in), .hop_ack(hop_ack), .ej1(ej1), .ej2(ej2),
      .busy(busy), .done(done), .err(err), .paid(paid), .short(short),
      .inv1(inv1), .inv2(inv2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // call at a negedge; acks each pulse one cycle after it ends (2-unit only if ack2)
   task automatic txn(input int amt, input bit ld, input int i1, input int i2,
                      input bit ack2, input bit poke);
      bit p1 = 0, p2 = 0, fin = 0;
      n1 = 0; n2 = 0; w1 = 0; w2 = 0; cyc = 0; both = 0;
      req = 1; amount = 3'(amt); inv_load = ld; inv1_in = 6'(i1); inv2_in = 6'(i2);
      @(posedge clk);
      #1 req = 0; inv_load = 0;
      for (int c = 1; c <= 200 && !fin; c++) begin
         @(negedge clk);
         hop_ack = 0; req = 0; inv_load = 0;
         if (ej1 && ej2) both++;
         if (ej1 && !p1) n1++;
         if (ej2 && !p2) n2++;
         w1 += int'(ej1);
         w2 += int'(ej2);
         if ((p2 && !ej2 && ack2) || (p1 && !ej1)) hop_ack = 1;
         if (poke && c == 3) begin
            req = 1; amount = 3'd5; inv_load = 1; inv1_in = 6'd9; inv2_in = 6'd9;
         end
         p1 = ej1; p2 = ej2;
         if (done) begin
            fin = 1;
            cyc = c;
         end
      end
      hop_ack = 0; req = 0; inv_load = 0;
      chk("done_seen", int'(fin), 1);
      chk("ej_overlap", both, 0);
   endtask

   initial begin
      #12;
      chk("rst_ej1", int'(ej1), 0);
      chk("rst_ej2", int'(ej2), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_paid", int'(paid), 0);
      chk("rst_short", int'(short), 0);
      chk("rst_inv1", int'(inv1), 0);
      chk("rst_inv2", int'(inv2), 0);
      @(negedge clk) rst = 1;
      // 1: 2+1 payout
      @(negedge clk) inv_load = 1; inv1_in = 5; inv2_in = 5;
      @(negedge clk) inv_load = 0;
      chk("t1_load1", int'(inv1), 5);
      txn(3, 0, 0, 0, 1, 0);
      chk("t1_n2", n2, 1); chk("t1_n1", n1, 1);
      chk("t1_w2", w2, 4); chk("t1_w1", w1, 4);
      chk("t1_cyc", cyc, 14);
      chk("t1_paid", int'(paid), 3); chk("t1_short", int'(short), 0); chk("t1_err", int'(err), 0);
      chk("t1_busy", int'(busy), 0);
      chk("t1_inv1", int'(inv1), 4); chk("t1_inv2", int'(inv2), 4);
      // 2: only 1-unit coins
      @(negedge clk);
      txn(4, 1, 5, 0, 1, 0);
      chk("t2_n1", n1, 4); chk("t2_n2", n2, 0); chk("t2_w1", w1, 16);
      chk("t2_cyc", cyc, 26);
      chk("t2_paid", int'(paid), 4); chk("t2_short", int'(short), 0); chk("t2_err", int'(err), 0);
      chk("t2_inv1", int'(inv1), 1);
      // 3: short, no overpay with 2-unit coins left
      @(negedge clk);
      txn(3, 1, 0, 3, 1, 0);
      chk("t3_n2", n2, 1); chk("t3_n1", n1, 0); chk("t3_cyc", cyc, 8);
      chk("t3_paid", int'(paid), 2); chk("t3_short", int'(short), 1); chk("t3_err", int'(err), 1);
      chk("t3_inv2", int'(inv2), 2);
      // 4: jammed 2-unit hopper falls back to 1-unit
      @(negedge clk);
      txn(2, 1, 5, 5, 0, 0);
      chk("t4_n2", n2, 1); chk("t4_n1", n1, 2); chk("t4_cyc", cyc, 35);
      chk("t4_paid", int'(paid), 2); chk("t4_short", int'(short), 0); chk("t4_err", int'(err), 1);
      chk("t4_inv2", int'(inv2), 0); chk("t4_inv1", int'(inv1), 3);
      // 5: zero amount, then req/inv_load while busy
      @(negedge clk);
      txn(0, 0, 0, 0, 1, 0);
      chk("t5_n", n1 + n2, 0); chk("t5_cyc", cyc, 2);
      chk("t5_paid", int'(paid), 0); chk("t5_short", int'(short), 0); chk("t5_err", int'(err), 0);
      @(negedge clk);
      txn(2, 0, 0, 0, 1, 1);
      chk("t5b_n1", n1, 2); chk("t5b_cyc", cyc, 14); chk("t5b_paid", int'(paid), 2);
      chk("t5b_inv1", int'(inv1), 1); chk("t5b_inv2", int'(inv2), 0);
      repeat (3) @(negedge clk);
      chk("t5b_idle", int'(busy), 0); chk("t5b_inv1_kept", int'(inv1), 1);
      // 6: async reset mid ej2 pulse
      req = 1; amount = 2; inv_load = 1; inv1_in = 5; inv2_in = 5;
      @(posedge clk);
      #1 req = 0; inv_load = 0;
      repeat (3) @(negedge clk);
      chk("t6_ej2_on", int'(ej2), 1);
      #2 rst = 0;
      #1;
      chk("t6_ej2", int'(ej2), 0); chk("t6_busy", int'(busy), 0);
      chk("t6_inv1", int'(inv1), 0); chk("t6_inv2", int'(inv2), 0);
      @(negedge clk) rst = 1;
      @(negedge clk);
      txn(1, 1, 3, 3, 1, 0);
      chk("t6_n1", n1, 1); chk("t6_n2", n2, 0); chk("t6_cyc", cyc, 8);
      chk("t6_paid", int'(paid), 1); chk("t6_err", int'(err), 0);
      chk("t6_inv1b", int'(inv1), 2); chk("t6_inv2b", int'(inv2), 3);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Payout end of the vending coin path. The vending controller accepts 1- and 2-unit coins and computes change or refund.
- This block takes that amount as a one-cycle request and physically pays it out. It drives eject pulses to a 2-unit and a 1-unit coin hopper, one coin at a time, and waits for each hopper's coin-passed acknowledge.
- It tracks hopper inventory, falls back to 1-unit coins when 2-unit coins are exhausted or jammed, and reports paid/short amounts.

Parameters:
AMT_W, 3, width of amount/paid/short (matches controller cng/rtn width)
CNT_W, 6, width of per-hopper inventory counters
PULSE_CYCLES, 4, eject pulse width in clk cycles (>=1)
ACK_TIMEOUT, 16, cycles waited in WAIT_ACK for hop_ack before declaring a jam (>=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (rst==0 resets)
req  in  1  payout request strobe, one cycle
amount  in  AMT_W  units to pay, sampled with req
inv_load  in  1  inventory load strobe
inv1_in  in  CNT_W  1-unit hopper count, loaded on inv_load
inv2_in  in  CNT_W  2-unit hopper count, loaded on inv_load
hop_ack  in  1  coin-passed sensor pulse from the active hopper
ej1  out  1  1-unit hopper eject pulse
ej2  out  1  2-unit hopper eject pulse
busy  out  1  transaction in progress
done  out  1  one-cycle completion pulse
err  out  1  transaction incomplete or jam occurred; valid with done, held until next accepted req
paid  out  AMT_W  units actually dispensed; held until next accepted req
short  out  AMT_W  units not dispensed (amount - paid); held until next accepted req
inv1  out  CNT_W  current 1-unit inventory
inv2  out  CNT_W  current 2-unit inventory

Behaviour:
- All outputs registered.
- Reset (rst low, asynchronous): state=IDLE; ej1=ej2=busy=done=err=0; paid=short=0; inv1=inv2=0. Eject lines drop immediately, including mid-pulse.
- FSM states: IDLE, SELECT, EJECT, WAIT_ACK, DONE.
- IDLE:
  - inv_load loads inv1/inv2.
  - req latches rem=amount, clears paid/short/err, sets busy, goes to SELECT.
  - req and inv_load in the same cycle: both take effect; SELECT sees the loaded counts.
  - amount==0: SELECT goes straight to DONE with paid=0, short=0, err=0.
- SELECT (one cycle):
  - rem==0: go to DONE.
  - rem>=2 and inv2>0: coin=2, go to EJECT.
  - else inv1>0: coin=1, go to EJECT.
  - else: short=rem, err=1, go to DONE. Never overpay: rem==1 with inv1==0 is short even if inv2>0.
- EJECT:
  - Asserts ej2 (coin=2) or ej1 (coin=1) for exactly PULSE_CYCLES cycles, then goes to WAIT_ACK with the timeout counter cleared.
  - The other eject line stays low. ej1 and ej2 are never high together.
  - hop_ack seen during EJECT is latched and honoured on the first WAIT_ACK cycle.
- WAIT_ACK:
  - hop_ack (or latched ack): rem-=coin, paid+=coin, matching inventory decrements by 1, go to SELECT.
  - No ack within ACK_TIMEOUT cycles: jam. Zero that denomination's inventory, set err=1, go to SELECT. This allows fallback, e.g. a jammed 2-unit hopper falls back to 1-unit coins.
  - Extra hop_ack pulses after the first for one eject are ignored.
- DONE (one cycle): done=1, busy=0, short=rem. Next state IDLE.
- req while busy is ignored (no queueing). inv_load while busy is ignored.
- hop_ack in IDLE, SELECT or DONE is ignored.
- Invariants: paid+short==amount at done; paid<=amount; inventories never decrement below 0.
- Latency, ample inventory, immediate ack:
  - req accepted on edge N.
  - EJECT pulse covers cycles N+2..N+1+PULSE_CYCLES.
  - Each coin costs PULSE_CYCLES+2 cycles (EJECT + one WAIT_ACK cycle + SELECT).
  - done follows the final SELECT by one cycle.

Decomposition:
- Shared package vend_pkg:
  - state encodings for this FSM
  - COIN1=1 and COIN2=2 denomination constants
  - default AMT_W (shared with the vending controller's cng/rtn width)
- One natural sub-module, dispense_timer: a loadable down-counter with terminal-count flag, reused for the eject pulse width and the ack timeout.

Test Plan:
1. inv_load inv1=5, inv2=5; req amount=3; ack 1 cycle after each pulse -> ej2 pulse (4 cycles), then ej1 pulse (4 cycles); done: paid=3, short=0, err=0; inv1=4, inv2=4.
2. inv1=5, inv2=0; req amount=4 -> four ej1 pulses; paid=4, short=0, err=0; inv1=1.
3. inv1=0, inv2=3; req amount=3 -> one ej2 pulse; done: paid=2, short=1, err=1; inv2=2.
4. inv1=5, inv2=5; req amount=2; never ack the ej2 pulse -> after 16 WAIT_ACK cycles inv2=0, err=1; two ej1 pulses follow (acked); done: paid=2, short=0, err=1.
5. req amount=0 -> no eject pulses; done 2 cycles after req; paid=0, short=0, err=0. Second req and an inv_load during a busy transaction -> ignored; inventory unchanged.
6. rst low midway through an ej2 pulse -> ej2, busy and inventories are 0 immediately. After release, req amount=1 with inv loaded -> normal single ej1 payout.
